// File: rtl/jogo_sequencia_param.sv
// Sequence memory game: replay the stored plays, then append a new one.
// Ports: clock/reset, iniciar, nivel, botoes in; leds, pronto/ganhou/perdeu, db_* out.
// Macro JOGO_TIMEOUT_EN builds the per-play timer and timeout loss path.
module jogo_sequencia_param #(
  parameter int N_BOTOES     = 4,
  parameter int PROFUNDIDADE = 16,
  parameter int SEMENTE      = 1,
  parameter int TIMEOUT      = 5000,
  localparam int AW          = $clog2(PROFUNDIDADE)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                nivel,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic [3:0]          db_estado,
  output logic [AW-1:0]       db_rodada,
  output logic [AW-1:0]       db_contagem,
  output logic                db_timeout
);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    ESPERA      = 4'd2,
    COMPARA     = 4'd3,
    PROX_JOGADA = 4'd4,
    ESPERA_NOVA = 4'd5,
    GRAVA       = 4'd6,
    PROX_RODADA = 4'd7,
    GANHOU      = 4'd8,
    PERDEU      = 4'd9
  } estado_t;

  function automatic logic um_quente(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  estado_t estado;
  estado_t prox;

  logic [N_BOTOES-1:0] mem [PROFUNDIDADE];
  logic [AW-1:0]       rodada;
  logic [AW-1:0]       contagem;
  logic [AW-1:0]       ultima;
  logic                ativo_ant;
  logic                jogada;
  logic                acerto;
  logic                fim_tempo;

  // History tracks every cycle, so an edge seen outside the
  // waiting states is consumed rather than replayed later.
  assign jogada = (|botoes) & ~ativo_ant;
  assign acerto = (leds == mem[contagem]) && um_quente(leds);

  assign db_estado   = estado;
  assign db_rodada   = rodada;
  assign db_contagem = contagem;

`ifdef JOGO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;

  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
    end else if (prox != estado) begin
      timer <= '0;
    end else if (estado == ESPERA || estado == ESPERA_NOVA) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end

  assign fim_tempo = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      db_timeout <= 1'b0;
    end else if (estado == PREPARA) begin
      db_timeout <= 1'b0;
    end else if ((estado == ESPERA || estado == ESPERA_NOVA)
                 && !jogada && fim_tempo) begin
      db_timeout <= 1'b1;
    end
  end
`else
  assign fim_tempo  = 1'b0;
  assign db_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      INICIAL:     if (iniciar) prox = PREPARA;
      PREPARA:     prox = ESPERA;
      ESPERA: begin
        if (jogada)         prox = COMPARA;
        else if (fim_tempo) prox = PERDEU;
      end
      COMPARA: begin
        if (!acerto)                prox = PERDEU;
        else if (contagem < rodada) prox = PROX_JOGADA;
        else if (rodada == ultima)  prox = GANHOU;
        else                        prox = ESPERA_NOVA;
      end
      PROX_JOGADA: prox = ESPERA;
      ESPERA_NOVA: begin
        if (jogada)         prox = um_quente(botoes) ? GRAVA : PERDEU;
        else if (fim_tempo) prox = PERDEU;
      end
      GRAVA:       prox = PROX_RODADA;
      PROX_RODADA: prox = ESPERA;
      GANHOU,
      PERDEU:      if (iniciar) prox = PREPARA;
      default:     prox = INICIAL;
    endcase
  end

  always_comb begin
    pronto = 1'b0;
    ganhou = 1'b0;
    perdeu = 1'b0;
    unique case (1'b1)
      (estado == GANHOU): begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      (estado == PERDEU): begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      leds      <= '0;
      rodada    <= '0;
      contagem  <= '0;
      ultima    <= '0;
      ativo_ant <= 1'b0;
    end else begin
      ativo_ant <= |botoes;
      unique case (estado)
        PREPARA: begin
          leds     <= '0;
          rodada   <= '0;
          contagem <= '0;
          ultima   <= nivel ? AW'(PROFUNDIDADE - 1)
                            : AW'(PROFUNDIDADE / 2 - 1);
        end
        ESPERA,
        ESPERA_NOVA: if (jogada) leds <= botoes;
        PROX_JOGADA: contagem <= contagem + 1'b1;
        PROX_RODADA: begin
          rodada   <= rodada + 1'b1;
          contagem <= '0;
        end
        default: ;
      endcase
    end
  end

  // Sequence memory survives reset and restarts; only slot 0 is reseeded.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (estado == PREPARA)
        mem[0] <= N_BOTOES'(SEMENTE);
      else if (estado == GRAVA)
        mem[rodada + AW'(1)] <= leds;
    end
  end

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Randomized bench for jogo_sequencia_param against a round-level game model.
// Model: array of stored plays; each round replays 0..r, then appends one play.
module tb_jogo_sequencia_param;

  localparam int NB = 4;
  localparam int PR = 16;
  localparam int AW = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          iniciar;
  logic          nivel;
  logic [NB-1:0] botoes;
  logic [NB-1:0] leds;
  logic          pronto, ganhou, perdeu;
  logic [3:0]    db_estado;
  logic [AW-1:0] db_rodada, db_contagem;
  logic          db_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NB-1:0] ref_mem [PR];

  always #5 clk = ~clk;

  jogo_sequencia_param #(
    .N_BOTOES(NB), .PROFUNDIDADE(PR), .SEMENTE(1), .TIMEOUT(TO)
  ) dut (
    .clock(clk), .reset(reset), .iniciar(iniciar), .nivel(nivel),
    .botoes(botoes), .leds(leds), .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .db_estado(db_estado), .db_rodada(db_rodada),
    .db_contagem(db_contagem), .db_timeout(db_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_leds"}, leds, 0);
    check({tag, "_pronto"}, pronto, 0);
    check({tag, "_ganhou"}, ganhou, 0);
    check({tag, "_perdeu"}, perdeu, 0);
    check({tag, "_rodada"}, db_rodada, 0);
    check({tag, "_contagem"}, db_contagem, 0);
    check({tag, "_timeout"}, db_timeout, 0);
  endtask

  task automatic dut_reset();
    @(negedge clk);
    reset = 1'b1; iniciar = 1'b0; botoes = '0;
    @(posedge clk); #1;
    check("rst_estado", db_estado, 0);
    check_idle_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns just after the edge that enters the waiting state.
  task automatic start(input bit niv);
    @(negedge clk);
    iniciar = 1'b1; nivel = niv;
    @(posedge clk); #1;
    check("start_prepara", db_estado, 1);
    @(negedge clk);
    iniciar = 1'b0;
    @(posedge clk); #1;
    check("start_espera", db_estado, 2);
    check_idle_outputs("start");
    nivel = 1'($urandom_range(0, 1));
  endtask

  // One press: l0/e0 sampled after the detection edge, e1/e2 one and
  // two edges later. Hold+gap >= 4 keeps presses inside waiting states.
  task automatic jogar(input logic [NB-1:0] b, output logic [NB-1:0] l0,
                       output logic [3:0] e0, output logic [3:0] e1,
                       output logic [3:0] e2);
    int h, g;
    h = $urandom_range(1, 8);
    g = $urandom_range(3, 8);
    e1 = 'x; e2 = 'x;
    @(negedge clk);
    botoes = b;
    @(posedge clk); #1;
    l0 = leds; e0 = db_estado;
    for (int k = 1; k < h + g; k++) begin
      @(negedge clk);
      if (k == h) botoes = '0;
      @(posedge clk); #1;
      if (k == 1) e1 = db_estado;
      if (k == 2) e2 = db_estado;
    end
  endtask

  // erro_t: 0 wrong one-hot replay, 1 non-one-hot new play,
  // 2 non-one-hot replay. rst_r: reset at start of that round.
  task automatic jogo(input bit do_start, input bit niv, input int erro_r,
                      input int erro_t, input int rst_r);
    int ult;
    logic [NB-1:0] b, l0;
    logic [3:0] e0, e1, e2;
    if (do_start) start(niv);
    ult = niv ? PR - 1 : PR / 2 - 1;
    ref_mem[0] = 4'b0001;
    for (int r = 0; r <= ult; r++) begin
      for (int i = 0; i <= r; i++) begin
        check("pre_estado", db_estado, 2);
        check("pre_rodada", db_rodada, r);
        check("pre_contagem", db_contagem, i);
        if (r == rst_r && i == 0) begin
          dut_reset();
          return;
        end
        b = ref_mem[i];
        if (r == erro_r && i == r && erro_t == 0) b = {b[2:0], b[3]};
        if (r == erro_r && i == r && erro_t == 2) b = 4'b0110;
        jogar(b, l0, e0, e1, e2);
        check("play_leds", l0, b);
        check("play_compara", e0, 3);
        if (b != ref_mem[i]) begin
          check("wrong_perdeu_state", e1, 9);
          check("wrong_perdeu", perdeu, 1);
          check("wrong_pronto", pronto, 1);
          check("wrong_ganhou", ganhou, 0);
          check("wrong_timeout", db_timeout, 0);
          check("wrong_leds", leds, b);
          return;
        end
        if (i < r) begin
          check("next_play_e1", e1, 4);
          check("next_play_e2", e2, 2);
        end else if (r == ult) begin
          check("win_e1", e1, 8);
          check("win_e2", e2, 8);
          check("win_ganhou", ganhou, 1);
          check("win_pronto", pronto, 1);
          check("win_perdeu", perdeu, 0);
          check("win_rodada", db_rodada, ult);
          check("win_contagem", db_contagem, ult);
          check("win_leds", leds, b);
          return;
        end else begin
          check("new_wait_e1", e1, 5);
          check("new_wait_e2", e2, 5);
        end
      end
      check("pre_new_estado", db_estado, 5);
      if (r == erro_r && erro_t == 1) begin
        b = 4'b0011;
        jogar(b, l0, e0, e1, e2);
        check("inval_perdeu_state", e0, 9);
        check("inval_perdeu", perdeu, 1);
        check("inval_leds", leds, b);
        check("inval_timeout", db_timeout, 0);
        return;
      end
      b = 4'b0001 << $urandom_range(0, 3);
      ref_mem[r + 1] = b;
      jogar(b, l0, e0, e1, e2);
      check("new_leds", l0, b);
      check("new_grava", e0, 6);
      check("new_prox_rodada", e1, 7);
      check("new_espera", e2, 2);
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; nivel = 1'b0; botoes = '0;
    repeat (2) @(posedge clk);
    #1;
    check("por_estado", db_estado, 0);
    check_idle_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    jogo(1, 1, -1, 0, -1);

    // iniciar held through GANHOU while a button is held: the game
    // restarts and the already-high button is not taken as a play.
    @(negedge clk);
    iniciar = 1'b1; nivel = 1'b0; botoes = 4'b0100;
    @(posedge clk); #1;
    check("held_prepara", db_estado, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("held_espera", db_estado, 2);
    end
    @(negedge clk);
    iniciar = 1'b0; botoes = '0;
    @(posedge clk); #1;
    jogo(0, 0, -1, 0, -1);

    jogo(1, 1, 2, 0, -1);
    jogo(1, 1, 1, 1, -1);
    jogo(1, 0, 3, 2, -1);
    jogo(1, 1, -1, 0, 3);
    jogo(1, 0, -1, 0, -1);

`ifdef JOGO_TIMEOUT_EN
    start(1);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("to_not_yet", perdeu, 0);
    @(posedge clk); #1;
    check("to_perdeu", perdeu, 1);
    check("to_flag", db_timeout, 1);
    check("to_estado", db_estado, 9);
    start(0);
`else
    start(1);
    repeat (3 * TO) @(posedge clk);
    #1;
    check("no_to_estado", db_estado, 2);
    check("no_to_flag", db_timeout, 0);
`endif
    dut_reset();

    for (int n = 0; n < 4; n++) begin
      jogo(1, 1'($urandom_range(0, 1)), $urandom_range(0, 6),
           $urandom_range(0, 2), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
